spi_lcd_tx: RTL and testbench
=============================

# spi_lcd_tx

Transmit side of the display link: accepts 9-bit words from the frame buffer over a valid/ready handshake and serializes them onto a 4-wire SPI master port (SCLK, MOSI, CS_N, D/C) toward the LCD controller. Bit 8 of each word is the mode bit (1 = pixel/data, 0 = command) and drives the D/C line; bits 7:0 are shifted out MSB first, SPI mode 0 (CPOL=0, CPHA=0). One word per chip-select frame.

## Interface
- CLK_DIV, default 2: SCLK half-period in clk cycles; legal range 1..255.
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  producer has a word on i_data.
- i_data  input  9  [8] mode (D/C), [7:0] byte to shift.
- o_ready  output  1  block can accept a word this cycle.
- o_sclk  output  1  SPI clock, idle low.
- o_mosi  output  1  serial data, MSB first.
- o_cs_n  output  1  active-low chip select, one frame per word.
- o_dc  output  1  data/command line to LCD.
- o_busy  output  1  high while a frame is in progress (cs_n low).

## Operation
- All outputs registered; no combinational path from inputs to outputs.
- Reset (reset_n low, takes effect immediately, no clock needed): state IDLE, o_ready=0, o_sclk=0, o_mosi=0, o_cs_n=1, o_dc=0, o_busy=0, counters 0. o_ready rises on first clk edge after reset_n deasserts.
- Handshake: transfer occurs on a rising edge where i_valid && o_ready. o_ready is high only in IDLE. Producer must hold i_data stable while i_valid && !o_ready; dropping i_valid before acceptance is legal and transfers nothing.
- States:
  - IDLE: o_ready=1, o_cs_n=1, o_sclk=0. On transfer: latch i_data[7:0] into 8-bit shift register, o_dc<=i_data[8], o_mosi<=i_data[7], o_cs_n<=0, o_busy<=1, o_ready<=0, -> SETUP.
  - SETUP: o_sclk low for CLK_DIV cycles (MOSI setup before first edge), -> HIGH.
  - HIGH: o_sclk high for CLK_DIV cycles (LCD samples on rising edge), -> LOW.
  - LOW: o_sclk low for CLK_DIV cycles. On entry, if bits remain, o_mosi<=next bit. After CLK_DIV cycles: if bit counter < 7, increment, -> HIGH; else -> IDLE with o_cs_n<=1, o_busy<=0, o_ready<=1.
- Bit counter 3 bits, 0..7; divider counter 8 bits, counts 0..CLK_DIV-1 then reloads.
- After the 8th bit, o_mosi holds bit 0 through final LOW phase; returns to 0 on entering IDLE. o_dc holds last value until next accepted word.
- Exactly 8 rising SCLK edges per frame; o_sclk never toggles while o_cs_n=1.
- Reset mid-frame: outputs jump to reset values asynchronously (partial frame abandoned, cs_n deasserts); no word is resumed.

## Timing
- Transfer at edge T0: o_cs_n, o_dc, o_mosi (bit 7) valid from T0+1.
- Rising SCLK edge for bit k (k=0 is MSB): o_sclk high from T0+1+CLK_DIV+2k*CLK_DIV for CLK_DIV cycles.
- MOSI changes only together with SCLK falling edge (or at frame start); setup and hold to rising edge each = CLK_DIV cycles.
- o_cs_n low for exactly 17*CLK_DIV cycles; o_cs_n high and o_ready high together at T0+1+17*CLK_DIV.
- Earliest next transfer at that edge; o_cs_n high at least 1 cycle between frames. Minimum word period 17*CLK_DIV+1 cycles (CLK_DIV=2: 35 cycles).

## Test plan
- Reset then send 0x1A5 (CLK_DIV=2) -> o_dc=1, MOSI bits 1,0,1,0,0,1,0,1 sampled on 8 SCLK rising edges, cs_n low exactly 34 cycles, o_ready back high at T0+35.
- Send 0x03C (command) -> o_dc=0 for whole frame, byte 0x3C received by SPI slave model; o_dc stays 0 after frame.
- i_valid held high with 4 queued words 0x100..0x103 -> four frames, each separated by exactly one cs_n-high cycle, word period 35 cycles, each byte captured correctly.
- CLK_DIV=1, send 0x1FF then 0x000 -> SCLK period 2 cycles, cs_n low 17 cycles per frame, MOSI all ones then all zeros.
- Assert reset_n low after 3rd SCLK rising edge -> same cycle o_cs_n=1, o_sclk=0, o_mosi=0, o_dc=0, o_ready=0; after release, o_ready=1 next edge and new word 0x155 transmits cleanly.
- i_valid pulsed while o_ready=0 mid-frame, i_data changed -> no extra frame, in-flight byte unaffected.

Source files
------------

// File: rtl/spi_lcd_tx.sv
// Display-link transmitter: takes 9-bit words (mode bit + byte) over valid/ready
// and shifts each byte out MSB first as one SPI mode-0 frame with D/C.
module spi_lcd_tx #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_valid,
  input  logic [8:0] i_data,
  output logic       o_ready,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_cs_n,
  output logic       o_dc,
  output logic       o_busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BIT_W  = 3;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div_cnt, div_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [BYTE_W-1:0]   shreg, shreg_nxt;
  logic                ready_nxt, sclk_nxt, mosi_nxt, cs_nxt, dc_nxt, busy_nxt;
  logic                div_done;

  assign div_done = (div_cnt == DIV_LAST);

  // State and all outputs are registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      o_ready <= 1'b0;
      o_sclk  <= 1'b0;
      o_mosi  <= 1'b0;
      o_cs_n  <= 1'b1;
      o_dc    <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      o_ready <= ready_nxt;
      o_sclk  <= sclk_nxt;
      o_mosi  <= mosi_nxt;
      o_cs_n  <= cs_nxt;
      o_dc    <= dc_nxt;
      o_busy  <= busy_nxt;
    end
  end

  // Each non-idle state lasts CLK_DIV cycles; transitions happen when the divider wraps
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    ready_nxt = o_ready;
    sclk_nxt  = o_sclk;
    mosi_nxt  = o_mosi;
    cs_nxt    = o_cs_n;
    dc_nxt    = o_dc;
    busy_nxt  = o_busy;

    if (state != IDLE) begin
      div_nxt = div_done ? '0 : div_cnt + DIV_W'(1);
    end

    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        sclk_nxt  = 1'b0;
        cs_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        div_nxt   = '0;
        bit_nxt   = '0;
        if (i_valid && o_ready) begin
          shreg_nxt = i_data[BYTE_W-1:0];
          dc_nxt    = i_data[BYTE_W];
          mosi_nxt  = i_data[BYTE_W-1];
          cs_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (div_done) begin
          sclk_nxt  = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        // Next bit is launched with the falling SCLK edge; the last bit is held
        if (div_done) begin
          sclk_nxt  = 1'b0;
          state_nxt = LOW;
          if (bit_cnt != BIT_LAST) begin
            mosi_nxt  = shreg[BYTE_W-2];
            shreg_nxt = {shreg[BYTE_W-2:0], 1'b0};
          end
        end
      end
      LOW: begin
        if (div_done) begin
          if (bit_cnt != BIT_LAST) begin
            bit_nxt   = bit_cnt + BIT_W'(1);
            sclk_nxt  = 1'b1;
            state_nxt = HIGH;
          end else begin
            cs_nxt    = 1'b1;
            busy_nxt  = 1'b0;
            ready_nxt = 1'b1;
            mosi_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_lcd_tx.sv
// Directed bench for spi_lcd_tx: one instance at CLK_DIV=2, one at CLK_DIV=1,
// each watched by an SPI slave model that records every chip-select frame.
module tb_spi_lcd_tx;

  typedef struct {
    int byte_v;
    int dc;
    int edges;
    int low_len;
    int first_rise;
    int start;
    int dc_bad;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] valid;
  logic [8:0] data0, data1;
  logic [1:0] ready, sclk, mosi, cs_n, dc, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_lcd_tx #(.CLK_DIV(2)) u_dut_div2 (
    .clk(clk), .reset_n(reset_n), .i_valid(valid[0]), .i_data(data0),
    .o_ready(ready[0]), .o_sclk(sclk[0]), .o_mosi(mosi[0]), .o_cs_n(cs_n[0]),
    .o_dc(dc[0]), .o_busy(busy[0])
  );

  spi_lcd_tx #(.CLK_DIV(1)) u_dut_div1 (
    .clk(clk), .reset_n(reset_n), .i_valid(valid[1]), .i_data(data1),
    .o_ready(ready[1]), .o_sclk(sclk[1]), .o_mosi(mosi[1]), .o_cs_n(cs_n[1]),
    .o_dc(dc[1]), .o_busy(busy[1])
  );

  // Slave model state, one slot per instance
  frame_t     fq0[$];
  frame_t     fq1[$];
  frame_t     mf;
  logic [1:0] in_fr, psclk, dc0, dcbad;
  logic [7:0] sh [2];
  int         ed [2];
  int         len [2];
  int         fr [2];
  int         st [2];
  int         idle_tog [2];

  initial begin
    in_fr = '0; psclk = '0; dc0 = '0; dcbad = '0;
    for (int d = 0; d < 2; d++) begin
      sh[d] = '0; ed[d] = 0; len[d] = 0; fr[d] = -1; st[d] = 0; idle_tog[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!reset_n) begin
          in_fr[d] = 1'b0;
          psclk[d] = 1'b0;
        end else begin
          if (!cs_n[d]) begin
            if (!in_fr[d]) begin
              in_fr[d] = 1'b1; sh[d] = '0; ed[d] = 0; len[d] = 0; fr[d] = -1;
              st[d] = cyc; dc0[d] = dc[d]; dcbad[d] = 1'b0;
            end
            len[d]++;
            if (dc[d] !== dc0[d]) dcbad[d] = 1'b1;
            if (sclk[d] && !psclk[d]) begin
              if (fr[d] < 0) fr[d] = cyc - st[d];
              sh[d] = {sh[d][6:0], mosi[d]};
              ed[d]++;
            end
          end else begin
            if (in_fr[d]) begin
              mf.byte_v = int'(sh[d]); mf.dc = int'(dc0[d]); mf.edges = ed[d];
              mf.low_len = len[d]; mf.first_rise = fr[d]; mf.start = st[d];
              mf.dc_bad = int'(dcbad[d]);
              if (d == 0) fq0.push_back(mf); else fq1.push_back(mf);
              in_fr[d] = 1'b0;
            end
            if (sclk[d]) idle_tog[d]++;
          end
          psclk[d] = sclk[d];
        end
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [8:0] w);
    if (d == 0) begin valid[0] = v; data0 = w; end
    else begin valid[1] = v; data1 = w; end
  endtask

  // Offer a word, wait for acceptance, then count cycles until o_ready returns
  task automatic send_wait(input int d, input logic [8:0] w, output int lat);
    int n;
    @(negedge clk);
    drive(d, 1'b1, w);
    n = 0;
    while (!ready[d] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    drive(d, 1'b0, w);
    check("busy_on", int'(busy[d]), 1);
    check("cs_low", int'(cs_n[d]), 0);
    lat = 1;
    while (!ready[d] && lat < 200) begin @(negedge clk); lat++; end
    @(negedge clk);
  endtask

  task automatic get_frame(input int d, output frame_t f);
    int n;
    f = '{default: 0};
    n = 0;
    while (((d == 0) ? fq0.size() : fq1.size()) == 0 && n < 100) begin
      @(negedge clk); n++;
    end
    if (d == 0 && fq0.size() > 0) f = fq0.pop_front();
    else if (d == 1 && fq1.size() > 0) f = fq1.pop_front();
    else check("frame_timeout", 0, 1);
  endtask

  task automatic check_frame(input string tag, input frame_t f, input int exp_byte,
                             input int exp_dc, input int exp_len, input int exp_rise);
    check({tag, "_byte"}, f.byte_v, exp_byte);
    check({tag, "_dc"}, f.dc, exp_dc);
    check({tag, "_dc_stable"}, f.dc_bad, 0);
    check({tag, "_edges"}, f.edges, 8);
    check({tag, "_cs_len"}, f.low_len, exp_len);
    check({tag, "_first_rise"}, f.first_rise, exp_rise);
  endtask

  initial begin
    frame_t f, pf;
    int     lat, n, r;
    logic   pr;

    valid = '0; data0 = '0; data1 = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_cs_n", int'(cs_n[0]), 1);
    check("rst_ready", int'(ready[0]), 0);
    check("rst_sclk", int'(sclk[0]), 0);
    check("rst_mosi", int'(mosi[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_dc", int'(dc[0]), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", int'(ready[0]), 1);

    // Data word 0x1A5
    send_wait(0, 9'h1A5, lat);
    check("lat_1a5", lat, 35);
    get_frame(0, f);
    check_frame("f1a5", f, 8'hA5, 1, 34, 2);
    check("busy_off", int'(busy[0]), 0);
    check("mosi_idle", int'(mosi[0]), 0);

    // Command word 0x03C
    send_wait(0, 9'h03C, lat);
    check("lat_03c", lat, 35);
    get_frame(0, f);
    check_frame("f03c", f, 8'h3C, 0, 34, 2);
    check("dc_hold", int'(dc[0]), 0);

    // Four back-to-back words with i_valid held high
    @(negedge clk);
    drive(0, 1'b1, 9'h100);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!ready[0] && n < 100) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      if (k < 3) drive(0, 1'b1, 9'(9'h101 + k));
      else drive(0, 1'b0, 9'h000);
    end
    for (int k = 0; k < 4; k++) begin
      get_frame(0, f);
      check_frame("burst", f, k, 1, 34, 2);
      if (k > 0) begin
        check("burst_period", f.start - pf.start, 35);
        check("burst_gap", f.start - (pf.start + pf.low_len), 1);
      end
      pf = f;
    end

    // CLK_DIV=1 instance
    send_wait(1, 9'h1FF, lat);
    check("lat_div1_ff", lat, 18);
    get_frame(1, f);
    check_frame("div1_ff", f, 8'hFF, 1, 17, 1);
    send_wait(1, 9'h000, lat);
    check("lat_div1_00", lat, 18);
    get_frame(1, f);
    check_frame("div1_00", f, 8'h00, 0, 17, 1);

    // Reset in the middle of a frame, after the 3rd rising SCLK edge
    @(negedge clk);
    drive(0, 1'b1, 9'h1AA);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 9'h1AA);
    r = 0; n = 0; pr = sclk[0];
    while (r < 3 && n < 200) begin
      @(negedge clk); n++;
      if (sclk[0] && !pr) r++;
      pr = sclk[0];
    end
    check("mid_dc_before", int'(dc[0]), 1);
    check("mid_mosi_before", int'(mosi[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_cs_n", int'(cs_n[0]), 1);
    check("mid_rst_sclk", int'(sclk[0]), 0);
    check("mid_rst_mosi", int'(mosi[0]), 0);
    check("mid_rst_dc", int'(dc[0]), 0);
    check("mid_rst_ready", int'(ready[0]), 0);
    check("mid_rst_busy", int'(busy[0]), 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("mid_ready_after", int'(ready[0]), 1);
    check("mid_no_frame", fq0.size(), 0);
    send_wait(0, 9'h155, lat);
    check("lat_155", lat, 35);
    get_frame(0, f);
    check_frame("f155", f, 8'h55, 1, 34, 2);

    // i_valid pulsed with different data while a frame is in flight
    @(negedge clk);
    drive(0, 1'b1, 9'h0C3);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 9'h0C3);
    repeat (10) @(negedge clk);
    drive(0, 1'b1, 9'h1FF);
    @(negedge clk);
    drive(0, 1'b0, 9'h000);
    n = 0;
    while (!ready[0] && n < 100) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    check("pulse_frames", fq0.size(), 1);
    get_frame(0, f);
    check_frame("fc3", f, 8'hC3, 0, 34, 2);

    check("idle_toggle_div2", idle_tog[0], 0);
    check("idle_toggle_div1", idle_tog[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
